// File: rtl/picorv32_mem_arbiter_if.sv
// picorv32_mem_arbiter_if: bundles the CPU native memory port, the host load/inspect
//    port and the single-port RAM port that the arbiter sits between.
//    Latency: none (wires only).  Backpressure: each side holds *_valid until its *_ready pulse.
//
// Signal groups:
//    CPU  : cpu_resetn, mem_valid/instr/addr/wdata/wstrb -> mem_ready/mem_rdata, cpu_oor
//    Host : host_halt, host_valid/we/addr/wdata -> host_ready/host_rdata
//    RAM  : ram_en/we/addr/wdata -> ram_rdata (one cycle after ram_en)
//
// Modports:
//    slave  : the arbiter's view (drives ready/rdata toward requesters and the RAM command)
//    master : the surrounding system's view (CPU, host and RAM model)

interface picorv32_mem_arbiter_if #(
   parameter int ADDR_WIDTH = 10
);
   // CPU side
   logic                  cpu_resetn;
   logic                  mem_valid;
   logic                  mem_instr;
   logic [31:0]           mem_addr;
   logic [31:0]           mem_wdata;
   logic [3:0]            mem_wstrb;
   logic                  mem_ready;
   logic [31:0]           mem_rdata;
   logic                  cpu_oor;

   // Host side
   logic                  host_halt;
   logic                  host_valid;
   logic                  host_we;
   logic [ADDR_WIDTH-1:0] host_addr;
   logic [31:0]           host_wdata;
   logic                  host_ready;
   logic [31:0]           host_rdata;

   // RAM side
   logic                  ram_en;
   logic [3:0]            ram_we;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [31:0]           ram_wdata;
   logic [31:0]           ram_rdata;

   modport slave (
      output cpu_resetn, mem_ready, mem_rdata, cpu_oor,
      output host_ready, host_rdata,
      output ram_en, ram_we, ram_addr, ram_wdata,
      input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
      input  host_halt, host_valid, host_we, host_addr, host_wdata,
      input  ram_rdata
   );

   modport master (
      input  cpu_resetn, mem_ready, mem_rdata, cpu_oor,
      input  host_ready, host_rdata,
      input  ram_en, ram_we, ram_addr, ram_wdata,
      output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
      output host_halt, host_valid, host_we, host_addr, host_wdata,
      output ram_rdata
   );
endinterface

// File: rtl/picorv32_mem_arbiter.sv
// picorv32_mem_arbiter: shares one single-port synchronous RAM between picorv32 and a host port,
//    and generates the CPU reset so the host can halt the core, load a program and release it.
//    Latency: request sampled in IDLE at t, RAM driven at t+1, ready pulse at t+2; one access per 3 cycles.
//    Backpressure: requesters hold *_valid until their one-cycle *_ready; the loser of a tie just waits.
//
// Ports:
//    clk      : sole clock, rising edge
//    resetn   : asynchronous active-low reset
//    bus      : picorv32_mem_arbiter_if.slave (CPU port, host port, RAM port, cpu_resetn, cpu_oor)
//
// Parameters:
//    ADDR_WIDTH   : RAM depth is 2**ADDR_WIDTH 32-bit words
//    RESET_CYCLES : cycles cpu_resetn stays low after resetn high and host_halt low (>= 1)

module picorv32_mem_arbiter #(
   parameter int ADDR_WIDTH   = 10,
   parameter int RESET_CYCLES = 16
) (
   input  logic                          clk,
   input  logic                          resetn,
   picorv32_mem_arbiter_if.slave         bus
);

   // ------------------------------------------------------------------
   // CPU reset generation
   // ------------------------------------------------------------------
   localparam int            CNT_W   = $clog2(RESET_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RESET_CYCLES);

   logic [CNT_W-1:0] rst_cnt;
   logic             cpu_resetn_q;

   // The counter saturates at RESET_CYCLES; cpu_resetn rises on the same edge
   // the counter reaches it, so the CPU sees exactly RESET_CYCLES low cycles.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rst_cnt      <= '0;
         cpu_resetn_q <= 1'b0;
      end else if (bus.host_halt) begin
         rst_cnt      <= '0;
         cpu_resetn_q <= 1'b0;
      end else if (rst_cnt != CNT_MAX) begin
         rst_cnt      <= rst_cnt + 1'b1;
         cpu_resetn_q <= (rst_cnt == CNT_MAX - 1'b1);
      end
   end

   assign bus.cpu_resetn = cpu_resetn_q;

   // ------------------------------------------------------------------
   // Request decode
   // ------------------------------------------------------------------
   // A CPU held in reset cannot be trusted to drive mem_valid sensibly.
   logic cpu_req;
   logic cpu_addr_oor;
   logic grant_cpu;

   assign cpu_req      = bus.mem_valid & cpu_resetn_q;
   assign cpu_addr_oor = |bus.mem_addr[31:ADDR_WIDTH+2];

   // Round robin on ties: the side that did not win last time gets it.
   // last_cpu resets to 0 (host last), so the CPU wins the first tie.
   logic last_cpu;
   assign grant_cpu = cpu_req & (~bus.host_valid | ~last_cpu);

   // Byte-lane bits of the CPU address and the fetch marker carry no
   // information for a word-wide RAM arbiter.
   logic unused_ok;
   assign unused_ok = &{1'b0, bus.mem_instr, bus.mem_addr[1:0]};

   // ------------------------------------------------------------------
   // Access sequencer
   // ------------------------------------------------------------------
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t                state;
   logic                  gnt_cpu_q;     // who owns the in-flight access
   logic                  rd_q;          // in-flight access returns RAM data
   logic                  mem_ready_q;
   logic                  host_ready_q;
   logic                  cpu_oor_q;
   logic                  ram_en_q;
   logic [3:0]            ram_we_q;
   logic [ADDR_WIDTH-1:0] ram_addr_q;
   logic [31:0]           ram_wdata_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state        <= IDLE;
         last_cpu     <= 1'b0;
         gnt_cpu_q    <= 1'b0;
         rd_q         <= 1'b0;
         mem_ready_q  <= 1'b0;
         host_ready_q <= 1'b0;
         cpu_oor_q    <= 1'b0;
         ram_en_q     <= 1'b0;
         ram_we_q     <= '0;
         ram_addr_q   <= '0;
         ram_wdata_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               mem_ready_q  <= 1'b0;
               host_ready_q <= 1'b0;
               ram_en_q     <= 1'b0;
               ram_we_q     <= '0;
               if (cpu_req || bus.host_valid) begin
                  state     <= ACCESS;
                  last_cpu  <= grant_cpu;
                  gnt_cpu_q <= grant_cpu;
                  if (grant_cpu) begin
                     // Out-of-range CPU addresses never reach the RAM:
                     // no enable, no write, zero data, sticky flag.
                     ram_en_q    <= ~cpu_addr_oor;
                     ram_we_q    <= cpu_addr_oor ? 4'b0000 : bus.mem_wstrb;
                     ram_addr_q  <= bus.mem_addr[ADDR_WIDTH+1:2];
                     ram_wdata_q <= bus.mem_wdata;
                     rd_q        <= ~cpu_addr_oor & (bus.mem_wstrb == 4'b0000);
                     if (cpu_addr_oor)
                        cpu_oor_q <= 1'b1;
                  end else begin
                     ram_en_q    <= 1'b1;
                     ram_we_q    <= {4{bus.host_we}};
                     ram_addr_q  <= bus.host_addr;
                     ram_wdata_q <= bus.host_wdata;
                     rd_q        <= ~bus.host_we;
                  end
               end
            end

            ACCESS: begin
               // RAM command lasts exactly this one cycle; its read data
               // appears during RESP, alongside the ready pulse.
               ram_en_q     <= 1'b0;
               ram_we_q     <= '0;
               mem_ready_q  <= gnt_cpu_q;
               host_ready_q <= ~gnt_cpu_q;
               state        <= RESP;
            end

            RESP: begin
               mem_ready_q  <= 1'b0;
               host_ready_q <= 1'b0;
               state        <= IDLE;
            end

            default: begin
               mem_ready_q  <= 1'b0;
               host_ready_q <= 1'b0;
               ram_en_q     <= 1'b0;
               ram_we_q     <= '0;
               state        <= IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign bus.ram_en     = ram_en_q;
   assign bus.ram_we     = ram_we_q;
   assign bus.ram_addr   = ram_addr_q;
   assign bus.ram_wdata  = ram_wdata_q;
   assign bus.mem_ready  = mem_ready_q;
   assign bus.host_ready = host_ready_q;
   assign bus.cpu_oor    = cpu_oor_q;

   // RAM data only arrives in RESP, so it is steered straight through; the
   // ready gate keeps both rdata buses at zero outside their own pulse.
   assign bus.mem_rdata  = (mem_ready_q  && rd_q) ? bus.ram_rdata : 32'h0;
   assign bus.host_rdata = (host_ready_q && rd_q) ? bus.ram_rdata : 32'h0;

endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// tb_picorv32_mem_arbiter: directed checks of reset generation, host/CPU accesses,
//    round-robin ties, out-of-range CPU accesses and reset in mid-access.
//    Includes a behavioural synchronous single-port RAM with byte enables.

module tb_picorv32_mem_arbiter;

   localparam int AW = 10;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   picorv32_mem_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

   picorv32_mem_arbiter #(
      .ADDR_WIDTH   (AW),
      .RESET_CYCLES (16)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   // Synchronous RAM: read data one cycle after ram_en.
   logic [31:0] ram [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (bus.ram_en) begin
         bus.ram_rdata <= ram[bus.ram_addr];
         for (int b = 0; b < 4; b++)
            if (bus.ram_we[b])
               ram[bus.ram_addr][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
      end
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One host access; lat = negedges until host_ready (0 = timed out).
   task automatic host_op(input logic we, input logic [AW-1:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output int lat, output int en_cnt);
      @(negedge clk);
      bus.host_valid = 1'b1; bus.host_we = we; bus.host_addr = addr; bus.host_wdata = wd;
      lat = 0; rd = '0; en_cnt = 0;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (bus.ram_en) en_cnt++;
         if (bus.host_ready) begin lat = i; rd = bus.host_rdata; break; end
      end
      bus.host_valid = 1'b0;
   endtask

   task automatic cpu_op(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wd,
                         output logic [31:0] rd, output int lat, output int en_cnt);
      @(negedge clk);
      bus.mem_valid = 1'b1; bus.mem_addr = addr; bus.mem_wstrb = strb; bus.mem_wdata = wd;
      lat = 0; rd = '0; en_cnt = 0;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (bus.ram_en) en_cnt++;
         if (bus.mem_ready) begin lat = i; rd = bus.mem_rdata; break; end
      end
      bus.mem_valid = 1'b0;
   endtask

   // CPU read of byte addr 0x14 and host read of word 5 raised together.
   task automatic tie_op(output int cl, output int hl, output logic [31:0] crd, output logic [31:0] hrd);
      @(negedge clk);
      bus.mem_valid = 1'b1; bus.mem_addr = 32'h14; bus.mem_wstrb = 4'h0; bus.mem_wdata = '0;
      bus.host_valid = 1'b1; bus.host_we = 1'b0; bus.host_addr = 10'd5; bus.host_wdata = '0;
      cl = 0; hl = 0; crd = '0; hrd = '0;
      for (int i = 1; i <= 15; i++) begin
         @(negedge clk);
         if (bus.mem_ready && cl == 0) begin cl = i; crd = bus.mem_rdata; bus.mem_valid = 1'b0; end
         if (bus.host_ready && hl == 0) begin hl = i; hrd = bus.host_rdata; bus.host_valid = 1'b0; end
         if (cl != 0 && hl != 0) break;
      end
      bus.mem_valid = 1'b0; bus.host_valid = 1'b0;
   endtask

   task automatic release_and_wait();
      @(negedge clk);
      resetn = 1'b1;
      repeat (16) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd, crd, hrd;
      int lat, en, cl, hl, cnt_rdy, cnt_en;

      for (int i = 0; i < (1<<AW); i++) ram[i] = '0;
      bus.mem_valid = 0; bus.mem_instr = 0; bus.mem_addr = '0; bus.mem_wdata = '0; bus.mem_wstrb = '0;
      bus.host_halt = 0; bus.host_valid = 0; bus.host_we = 0; bus.host_addr = '0; bus.host_wdata = '0;
      resetn = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_cpu_resetn", 32'(bus.cpu_resetn), 32'd0);
      chk("rst_ram_en",     32'(bus.ram_en),     32'd0);
      chk("rst_mem_ready",  32'(bus.mem_ready),  32'd0);
      chk("rst_host_ready", 32'(bus.host_ready), 32'd0);
      chk("rst_cpu_oor",    32'(bus.cpu_oor),    32'd0);
      chk("rst_ram_addr",   32'(bus.ram_addr),   32'd0);
      chk("rst_mem_rdata",  bus.mem_rdata,       32'd0);

      // cpu_resetn rises on the 16th edge after release
      @(negedge clk);
      resetn = 1'b1;
      repeat (15) @(negedge clk);
      chk("cpu_resetn_at_15", 32'(bus.cpu_resetn), 32'd0);
      @(negedge clk);
      chk("cpu_resetn_at_16", 32'(bus.cpu_resetn), 32'd1);

      // halt drops cpu_resetn next cycle; CPU requests ignored while halted
      bus.host_halt = 1'b1;
      @(negedge clk);
      chk("halt_cpu_resetn", 32'(bus.cpu_resetn), 32'd0);
      bus.mem_valid = 1'b1; bus.mem_addr = 32'h8; bus.mem_wstrb = 4'hF; bus.mem_wdata = 32'hBAD0BAD0;
      cnt_rdy = 0; cnt_en = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.mem_ready) cnt_rdy++;
         if (bus.ram_en) cnt_en++;
      end
      chk("halted_no_ready", 32'(cnt_rdy), 32'd0);
      chk("halted_no_ram_en", 32'(cnt_en), 32'd0);
      bus.mem_valid = 1'b0; bus.host_halt = 1'b0;
      repeat (15) @(negedge clk);
      chk("unhalt_at_15", 32'(bus.cpu_resetn), 32'd0);
      @(negedge clk);
      chk("unhalt_at_16", 32'(bus.cpu_resetn), 32'd1);

      // Host write then read
      host_op(1'b1, 10'd5, 32'hDEADBEEF, rd, lat, en);
      chk("host_wr_lat", 32'(lat), 32'd2);
      chk("host_wr_en_pulses", 32'(en), 32'd1);
      chk("host_wr_rdata", rd, 32'd0);
      host_op(1'b0, 10'd5, 32'h0, rd, lat, en);
      chk("host_rd_lat", 32'(lat), 32'd2);
      chk("host_rd_data", rd, 32'hDEADBEEF);

      // CPU byte-lane write over a host-loaded word
      host_op(1'b1, 10'd5, 32'h11223344, rd, lat, en);
      cpu_op(32'h14, 4'b0010, 32'h0000AA00, rd, lat, en);
      chk("cpu_wr_lat", 32'(lat), 32'd2);
      chk("cpu_wr_en_pulses", 32'(en), 32'd1);
      chk("cpu_wr_rdata", rd, 32'd0);
      cpu_op(32'h14, 4'b0000, 32'h0, rd, lat, en);
      chk("cpu_rd_lat", 32'(lat), 32'd2);
      chk("cpu_rd_data", rd, 32'h1122AA44);
      chk("cpu_oor_clear", 32'(bus.cpu_oor), 32'd0);

      // Out-of-range CPU accesses
      cpu_op(32'h0001_0000, 4'b0000, 32'h0, rd, lat, en);
      chk("oor_rd_lat", 32'(lat), 32'd2);
      chk("oor_rd_no_en", 32'(en), 32'd0);
      chk("oor_rd_data", rd, 32'd0);
      chk("oor_sticky", 32'(bus.cpu_oor), 32'd1);
      cpu_op(32'h0001_0014, 4'hF, 32'hFFFFFFFF, rd, lat, en);
      chk("oor_wr_no_en", 32'(en), 32'd0);
      host_op(1'b0, 10'd5, 32'h0, rd, lat, en);
      chk("oor_wr_dropped", rd, 32'h1122AA44);
      chk("oor_still_set", 32'(bus.cpu_oor), 32'd1);

      // Fresh reset: first tie goes to CPU
      @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      chk("rst2_oor_cleared", 32'(bus.cpu_oor), 32'd0);
      release_and_wait();
      chk("rst2_cpu_resetn", 32'(bus.cpu_resetn), 32'd1);
      tie_op(cl, hl, crd, hrd);
      chk("tie1_cpu_lat", 32'(cl), 32'd2);
      chk("tie1_host_lat", 32'(hl), 32'd5);
      chk("tie1_cpu_data", crd, 32'h1122AA44);
      chk("tie1_host_data", hrd, 32'h1122AA44);
      // CPU alone leaves last grant at CPU, so the next tie goes to the host
      cpu_op(32'h14, 4'b0000, 32'h0, rd, lat, en);
      chk("solo_cpu_lat", 32'(lat), 32'd2);
      tie_op(cl, hl, crd, hrd);
      chk("tie2_host_lat", 32'(hl), 32'd2);
      chk("tie2_cpu_lat", 32'(cl), 32'd5);

      // Reset during ACCESS
      @(negedge clk);
      bus.host_valid = 1'b1; bus.host_we = 1'b1; bus.host_addr = 10'd7; bus.host_wdata = 32'h55;
      @(negedge clk);
      chk("mid_access_ram_en", 32'(bus.ram_en), 32'd1);
      resetn = 1'b0;
      #1;
      chk("mid_rst_ram_en", 32'(bus.ram_en), 32'd0);
      chk("mid_rst_ram_we", 32'(bus.ram_we), 32'd0);
      chk("mid_rst_ram_addr", 32'(bus.ram_addr), 32'd0);
      chk("mid_rst_cpu_resetn", 32'(bus.cpu_resetn), 32'd0);
      bus.host_valid = 1'b0;
      cnt_rdy = 0;
      repeat (3) begin
         @(negedge clk);
         if (bus.host_ready || bus.mem_ready) cnt_rdy++;
      end
      chk("mid_rst_no_ready", 32'(cnt_rdy), 32'd0);
      release_and_wait();
      host_op(1'b0, 10'd5, 32'h0, rd, lat, en);
      chk("post_rst_lat", 32'(lat), 32'd2);
      chk("post_rst_data", rd, 32'h1122AA44);

      // Halt mid CPU access: the access still completes
      @(negedge clk);
      bus.mem_valid = 1'b1; bus.mem_addr = 32'h14; bus.mem_wstrb = 4'h0;
      @(negedge clk);
      bus.host_halt = 1'b1;
      @(negedge clk);
      chk("halt_mid_ready", 32'(bus.mem_ready), 32'd1);
      chk("halt_mid_data", bus.mem_rdata, 32'h1122AA44);
      chk("halt_mid_cpu_resetn", 32'(bus.cpu_resetn), 32'd0);
      bus.mem_valid = 1'b0; bus.host_halt = 1'b0;
      @(negedge clk);
      chk("after_ready_rdata_zero", bus.mem_rdata, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
